// File: rtl/instruction_fetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch stage and its consumers.
package instruction_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [0:XLEN-1] NOP_INSTR  = 32'h54000000;
  localparam logic [0:XLEN-1] TRAP_INSTR = 32'h44000300;
  localparam logic [0:XLEN-1] RESET_PC   = 32'h00000000;
  localparam int unsigned     PC_STEP    = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

endpackage : instruction_fetch_pkg

// File: rtl/instruction_fetch_pc_incrementer.sv
// Sequential PC successor: modulo-2^32 add of the fixed instruction step.
module pc_incrementer
  import instruction_fetch_pkg::*;
(
  input  logic [0:XLEN-1] pc_in,
  output logic [0:XLEN-1] pc_plus_step_c
);

  assign pc_plus_step_c = pc_in + XLEN'(PC_STEP);

endmodule : pc_incrementer

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, RUN/HALT FSM, IF/ID pipeline register and fetch counter.
module instruction_fetch
  import instruction_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_in,
  input  logic            redirect_in,
  input  logic [0:XLEN-1] redirect_pc_in,
  input  logic            trap_in,
  input  logic [0:XLEN-1] imem_data_in,
  output logic [0:XLEN-1] imem_addr_out,
  output logic [0:XLEN-1] instruction_out,
  output logic [0:XLEN-1] nextPC_out,
  output logic            valid_out,
  output logic            halted_out,
  output logic [0:XLEN-1] fetch_count_out
);

  fetch_state_t    r_state;
  fetch_state_t    w_next_state;
  logic [0:XLEN-1] r_pc;
  logic [0:XLEN-1] r_instr;
  logic [0:XLEN-1] r_next_pc;
  logic            r_valid;
  logic            r_halted;
  logic [0:XLEN-1] r_count;

  logic [0:XLEN-1] w_pc;
  logic [0:XLEN-1] w_instr;
  logic [0:XLEN-1] w_next_pc;
  logic            w_valid;
  logic            w_halted;
  logic [0:XLEN-1] w_count;
  logic [0:XLEN-1] w_pc_plus4;
  logic [0:XLEN-1] w_count_inc;

  pc_incrementer u_pc_inc (
    .pc_in          (r_pc),
    .pc_plus_step_c (w_pc_plus4)
  );

  assign w_count_inc = r_count + XLEN'(1);

  // Next-state and next-register values; priority trap > redirect > stall > fetch.
  always_comb begin
    w_next_state = r_state;
    w_pc         = r_pc;
    w_instr      = r_instr;
    w_next_pc    = r_next_pc;
    w_valid      = r_valid;
    w_count      = r_count;
    case (r_state)
      ST_RUN: begin
        if (trap_in) begin
          w_next_state = ST_HALT;
          w_instr      = NOP_INSTR;
          w_valid      = 1'b0;
        end else if (redirect_in) begin
          w_pc    = redirect_pc_in;
          w_instr = NOP_INSTR;
          w_valid = 1'b0;
        end else if (!stall_in) begin
          w_pc      = w_pc_plus4;
          w_instr   = imem_data_in;
          w_next_pc = w_pc_plus4;
          w_valid   = 1'b1;
          w_count   = w_count_inc;
        end
      end
      ST_HALT: begin
      end
      default: w_next_state = ST_RUN;
    endcase
    w_halted = (w_next_state == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_next_pc <= RESET_PC;
      r_valid   <= 1'b0;
      r_halted  <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_pc;
      r_instr   <= w_instr;
      r_next_pc <= w_next_pc;
      r_valid   <= w_valid;
      r_halted  <= w_halted;
      r_count   <= w_count;
    end
  end

  assign imem_addr_out   = r_pc;
  assign instruction_out = r_instr;
  assign nextPC_out      = r_next_pc;
  assign valid_out       = r_valid;
  assign halted_out      = r_halted;
  assign fetch_count_out = r_count;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; memory returns address ^ 32'hA5A5A5A5.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        stall_in;
  logic        redirect_in;
  logic [0:31] redirect_pc_in;
  logic        trap_in;
  logic [0:31] imem_data_in;
  logic [0:31] imem_addr_out;
  logic [0:31] instruction_out;
  logic [0:31] nextPC_out;
  logic        valid_out;
  logic        halted_out;
  logic [0:31] fetch_count_out;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [0:31] NOP = 32'h54000000;

  instruction_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .stall_in        (stall_in),
    .redirect_in     (redirect_in),
    .redirect_pc_in  (redirect_pc_in),
    .trap_in         (trap_in),
    .imem_data_in    (imem_data_in),
    .imem_addr_out   (imem_addr_out),
    .instruction_out (instruction_out),
    .nextPC_out      (nextPC_out),
    .valid_out       (valid_out),
    .halted_out      (halted_out),
    .fetch_count_out (fetch_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_data_in = imem_addr_out ^ 32'hA5A5A5A5;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [0:31] obs, input logic [0:31] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [0:31] pc, input logic [0:31] instr,
                           input logic [0:31] npc, input logic vld, input logic hlt,
                           input logic [0:31] cnt);
    check({tag, ".pc"},    imem_addr_out,           pc);
    check({tag, ".instr"}, instruction_out,         instr);
    check({tag, ".npc"},   nextPC_out,              npc);
    check({tag, ".valid"}, 32'(valid_out),          32'(vld));
    check({tag, ".halt"},  32'(halted_out),         32'(hlt));
    check({tag, ".count"}, fetch_count_out,         cnt);
  endtask

  initial begin
    reset = 1'b1; stall_in = 1'b0; redirect_in = 1'b0;
    redirect_pc_in = '0; trap_in = 1'b0;
    step(); step();
    check_all("reset", 32'h0, NOP, 32'h0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;

    // free run: mem[0], mem[4]
    step();
    check_all("run0", 32'h4, 32'hA5A5A5A5, 32'h4, 1'b1, 1'b0, 32'd1);
    step();
    check_all("run4", 32'h8, 32'hA5A5A5A1, 32'h8, 1'b1, 1'b0, 32'd2);

    // stall at PC=8 for two cycles
    stall_in = 1'b1;
    step();
    check_all("stall1", 32'h8, 32'hA5A5A5A1, 32'h8, 1'b1, 1'b0, 32'd2);
    step();
    check_all("stall2", 32'h8, 32'hA5A5A5A1, 32'h8, 1'b1, 1'b0, 32'd2);
    stall_in = 1'b0;
    step();
    check_all("run8", 32'hC, 32'hA5A5A5AD, 32'hC, 1'b1, 1'b0, 32'd3);

    // redirect beats stall at PC=12
    redirect_in = 1'b1; redirect_pc_in = 32'h00000100; stall_in = 1'b1;
    step();
    check_all("redir", 32'h100, NOP, 32'hC, 1'b0, 1'b0, 32'd3);
    redirect_in = 1'b0; stall_in = 1'b0;
    step();
    check_all("run100", 32'h104, 32'hA5A5A4A5, 32'h104, 1'b1, 1'b0, 32'd4);

    // PC wrap at top of address space
    redirect_in = 1'b1; redirect_pc_in = 32'hFFFFFFFC;
    step();
    check_all("redirtop", 32'hFFFFFFFC, NOP, 32'h104, 1'b0, 1'b0, 32'd4);
    redirect_in = 1'b0;
    step();
    check_all("wrap", 32'h0, 32'h5A5A5A59, 32'h0, 1'b1, 1'b0, 32'd5);
    step();
    check_all("after_wrap", 32'h4, 32'hA5A5A5A5, 32'h4, 1'b1, 1'b0, 32'd6);

    // unaligned redirect passes through, then reset during stall at 0x40
    redirect_in = 1'b1; redirect_pc_in = 32'h00000043;
    step();
    check("unaligned.pc", imem_addr_out, 32'h43);
    redirect_pc_in = 32'h00000040;
    step();
    check_all("redir40", 32'h40, NOP, 32'h4, 1'b0, 1'b0, 32'd6);
    redirect_in = 1'b0; stall_in = 1'b1; reset = 1'b1;
    step();
    check_all("rst_stall", 32'h0, NOP, 32'h0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    step();
    check_all("stall_post_rst", 32'h0, NOP, 32'h0, 1'b0, 1'b0, 32'd0);
    stall_in = 1'b0;
    step();
    check_all("run_post_rst", 32'h4, 32'hA5A5A5A5, 32'h4, 1'b1, 1'b0, 32'd1);

    // trap beats redirect, then HALT ignores everything
    trap_in = 1'b1; redirect_in = 1'b1; redirect_pc_in = 32'h00000200;
    step();
    check_all("trap", 32'h4, NOP, 32'h4, 1'b0, 1'b1, 32'd1);
    trap_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      redirect_in = i[0];
      stall_in    = i[1];
      trap_in     = i[2];
      step();
      check_all("halt", 32'h4, NOP, 32'h4, 1'b0, 1'b1, 32'd1);
    end
    trap_in = 1'b0; redirect_in = 1'b0; stall_in = 1'b0;
    reset = 1'b1;
    step();
    check_all("halt_rst", 32'h0, NOP, 32'h0, 1'b0, 1'b0, 32'd0);
    reset = 1'b0;
    step();
    check_all("resume", 32'h4, 32'hA5A5A5A5, 32'h4, 1'b1, 1'b0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall_in  in  1  hold PC and IF/ID register; from hazard unit.
- redirect_in  in  1  taken branch or jump resolved in ID.
- redirect_pc_in  in  [0:31]  target PC for a redirect.
- trap_in  in  1  trap instruction (32'h44000300) detected in ID.
- imem_data_in  in  [0:31]  combinational instruction-memory read data for imem_addr_out.
- imem_addr_out  out  [0:31]  current PC.
- instruction_out  out  [0:31]  IF/ID instruction register.
- nextPC_out  out  [0:31]  IF/ID register holding PC+4 of instruction_out.
- valid_out  out  1  instruction_out is a real fetched instruction, not a bubble.
- halted_out  out  1  FSM is in HALT.
- fetch_count_out  out  [0:31]  count of instructions delivered with valid_out=1.
REQ-002 All buses SHALL use big-endian numbering: bit 0 is the MSB.

Function
REQ-003 The FSM SHALL have two states, RUN and HALT, and SHALL leave HALT only through reset.
REQ-004 In RUN, each rising edge SHALL apply the first matching rule below, in priority order:
- a) trap_in=1: go to HALT, freeze PC, load bubble into IF/ID.
- b) redirect_in=1: PC <= redirect_pc_in; IF/ID <= bubble.
- c) stall_in=1: PC and IF/ID hold; fetch_count holds.
- d) normal: IF/ID <= {imem_data_in, PC+4, valid=1}; PC <= PC+4; fetch_count +1.
REQ-005 A bubble SHALL be instruction_out=NOP (32'h54000000), nextPC_out unchanged, valid_out=0.
REQ-006 redirect_in SHALL override a simultaneous stall_in.
REQ-007 trap_in SHALL override both redirect_in and stall_in.
REQ-008 Fetch latency SHALL be one cycle: the word at PC appears on instruction_out on the edge after PC is presented on imem_addr_out.
REQ-009 imem_addr_out SHALL equal the PC register combinationally.
REQ-010 PC+4 SHALL be computed modulo 2^32: 32'hFFFFFFFC wraps to 32'h00000000 with no flag.
REQ-011 redirect_pc_in SHALL be used as given, with no alignment check; bits [30:31] are passed through.
REQ-012 fetch_count_out SHALL wrap from 32'hFFFFFFFF to 0.
REQ-013 In HALT, the following SHALL hold constant: PC, instruction_out=NOP, valid_out=0, halted_out=1, fetch_count_out. stall_in, redirect_in and trap_in SHALL be ignored.

Reset
REQ-014 On reset=1 at a rising edge, the block SHALL set PC=32'h00000000, instruction_out=NOP, nextPC_out=0, valid_out=0, halted_out=0, fetch_count_out=0, and state=RUN.
REQ-015 Reset SHALL override every other input, including while in HALT and mid-stall.
REQ-016 The first fetch of address 0 SHALL be delivered on the first edge after reset deasserts.

Structure
REQ-017 A shared package SHALL hold: NOP_INSTR=32'h54000000, TRAP_INSTR=32'h44000300, RESET_PC=32'h00000000, PC_STEP=4, and the RUN/HALT state encoding.
REQ-018 The decode stage SHALL reference TRAP_INSTR from that package.
REQ-019 PC+4 SHALL be produced by one sub-module, pc_incrementer: 32-bit add of the constant PC_STEP.
REQ-020 fetch_count SHALL use its own increment.
REQ-021 The IF/ID register and the FSM SHALL be in instruction_fetch.

Verification
REQ-022 Reset then 3 free-run cycles, memory word at address = address^32'hA5A5A5A5 -> instruction_out = mem[0], mem[4], mem[8]; nextPC_out = 4, 8, 12; fetch_count_out=3.
REQ-023 stall_in=1 for 2 cycles at PC=8 -> imem_addr_out stays 8; instruction_out/nextPC_out hold mem[4]/8; count frozen; fetch resumes at 8.
REQ-024 redirect_in=1, redirect_pc_in=32'h00000100, with stall_in=1 at PC=12 -> next cycle PC=0x100, valid_out=0, instruction_out=NOP; following cycle instruction_out=mem[0x100], nextPC_out=0x104.
REQ-025 trap_in=1 together with redirect_in=1 -> halted_out=1, PC frozen, NOP/valid_out=0 for 10 further cycles; a later reset pulse -> PC=0, halted_out=0.
REQ-026 redirect to 32'hFFFFFFFC, then 2 free cycles -> nextPC_out=0; the second fetch is at address 0.
REQ-027 reset asserted during a stall with PC=0x40 -> all outputs at reset values on the next edge; stall_in is ignored on that edge.
